// File: rtl/rtc_bcd_scan.sv
// HH:MM:SS BCD timekeeper with a clock-enable prescaler, validated time-set,
// run/pause, a 12/24-hour display path and a 6-digit multiplexed 7-segment driver.
module rtc_bcd_scan #(
   parameter int unsigned CLK_HZ   = 50000000,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       mode_12h,
   input  logic       set_en,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm,
   output logic       sec_tick,
   output logic       day_wrap,
   output logic       set_err,
   output logic [6:0] seg,
   output logic [5:0] an
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

   logic [7:0]    r_hh, r_mm, r_ss;
   logic          r_pm, r_sec_tick, r_day_wrap, r_set_err;
   logic [PW-1:0] r_pre;
   logic [SW-1:0] r_scan;
   logic [2:0]    r_dig;
   logic [6:0]    r_seg;
   logic [5:0]    r_an;

   logic [7:0]    w_hh_nxt, w_mm_nxt, w_ss_nxt;
   logic [PW-1:0] w_pre_nxt;
   logic [SW-1:0] w_scan_nxt;
   logic [2:0]    w_dig_nxt;
   logic          w_tick, w_set_ok, w_sec_tick_nxt, w_day_wrap_nxt, w_set_err_nxt;
   logic          w_ss_top, w_mm_top, w_hh_top;
   logic [4:0]    w_hbin, w_h12bin;
   logic          w_h12_tens;
   logic [3:0]    w_h12_units, w_dh_tens, w_dh_units, w_digit;
   logic [6:0]    w_seg_nxt;
   logic [5:0]    w_an_nxt;

   // BCD increment that rolls to 00 after the given top value
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic nib_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Timekeeping next state: a valid set beats a coincident tick
   always_comb begin
      w_hh_nxt       = r_hh;
      w_mm_nxt       = r_mm;
      w_ss_nxt       = r_ss;
      w_pre_nxt      = r_pre;
      w_sec_tick_nxt = 1'b0;
      w_day_wrap_nxt = 1'b0;
      w_set_err_nxt  = 1'b0;

      w_tick   = run && (r_pre == PRE_MAX);
      w_ss_top = (r_ss == 8'h59);
      w_mm_top = (r_mm == 8'h59);
      w_hh_top = (r_hh == 8'h23);
      w_set_ok = set_en && nib_ok(set_hh) && nib_ok(set_mm) && nib_ok(set_ss) &&
                 (set_ss <= 8'h59) && (set_mm <= 8'h59) && (set_hh <= 8'h23);

      if (set_en && !w_set_ok)
         w_set_err_nxt = 1'b1;

      if (w_set_ok) begin
         w_hh_nxt  = set_hh;
         w_mm_nxt  = set_mm;
         w_ss_nxt  = set_ss;
         w_pre_nxt = '0;
      end else begin
         if (run)
            w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
         if (w_tick) begin
            w_sec_tick_nxt = 1'b1;
            w_day_wrap_nxt = w_ss_top && w_mm_top && w_hh_top;
            w_ss_nxt       = bcd_inc(r_ss, 8'h59);
            if (w_ss_top)
               w_mm_nxt = bcd_inc(r_mm, 8'h59);
            if (w_ss_top && w_mm_top)
               w_hh_nxt = bcd_inc(r_hh, 8'h23);
         end
      end
   end

   // Display path: 12-hour conversion, digit select, blanking and scan counters
   always_comb begin
      w_hbin   = 5'(r_hh[7:4]) * 5'd10 + 5'(r_hh[3:0]);
      w_h12bin = w_hbin;
      if (w_hbin == 5'd0)
         w_h12bin = 5'd12;
      else if (w_hbin > 5'd12)
         w_h12bin = w_hbin - 5'd12;
      w_h12_tens  = (w_h12bin >= 5'd10);
      w_h12_units = 4'(w_h12bin - (w_h12_tens ? 5'd10 : 5'd0));
      w_dh_tens   = mode_12h ? {3'b000, w_h12_tens} : r_hh[7:4];
      w_dh_units  = mode_12h ? w_h12_units : r_hh[3:0];

      case (r_dig)
         3'd0:    w_digit = r_ss[3:0];
         3'd1:    w_digit = r_ss[7:4];
         3'd2:    w_digit = r_mm[3:0];
         3'd3:    w_digit = r_mm[7:4];
         3'd4:    w_digit = w_dh_units;
         3'd5:    w_digit = w_dh_tens;
         default: w_digit = 4'hF;
      endcase

      w_seg_nxt = seg7(w_digit);
      if (mode_12h && (r_dig == 3'd5) && (w_dh_tens == 4'd0))
         w_seg_nxt = 7'h7F;
      w_an_nxt = ~(6'(1) << r_dig);

      w_scan_nxt = r_scan + SW'(1);
      w_dig_nxt  = r_dig;
      if (r_scan == SCAN_MAX) begin
         w_scan_nxt = '0;
         w_dig_nxt  = (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hh       <= 8'h00;
         r_mm       <= 8'h00;
         r_ss       <= 8'h00;
         r_pm       <= 1'b0;
         r_sec_tick <= 1'b0;
         r_day_wrap <= 1'b0;
         r_set_err  <= 1'b0;
         r_pre      <= '0;
         r_scan     <= '0;
         r_dig      <= 3'd0;
         r_an       <= 6'b111110;
         r_seg      <= 7'b1000000;
      end else begin
         r_hh       <= w_hh_nxt;
         r_mm       <= w_mm_nxt;
         r_ss       <= w_ss_nxt;
         r_pm       <= (w_hh_nxt >= 8'h12);
         r_sec_tick <= w_sec_tick_nxt;
         r_day_wrap <= w_day_wrap_nxt;
         r_set_err  <= w_set_err_nxt;
         r_pre      <= w_pre_nxt;
         r_scan     <= w_scan_nxt;
         r_dig      <= w_dig_nxt;
         r_an       <= w_an_nxt;
         r_seg      <= w_seg_nxt;
      end
   end

   assign hh       = r_hh;
   assign mm       = r_mm;
   assign ss       = r_ss;
   assign pm       = r_pm;
   assign sec_tick = r_sec_tick;
   assign day_wrap = r_day_wrap;
   assign set_err  = r_set_err;
   assign seg      = r_seg;
   assign an       = r_an;

endmodule
